// File: rtl/tx_sched_fsm.sv
// Round-robin transmit scheduler: grants one non-empty FIFO channel at a time and
// streams up to BURST words from it, one word per transmitter busy cycle.
module tx_sched_fsm #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned BURST = 4,
    localparam int unsigned CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] empty_fifo,
    input  logic            busy_tr,
    output logic [N_CH-1:0] re_fifo,
    output logic            start_tr,
    output logic [CW-1:0]   ch_sel,
    output logic            done,
    output logic            active
);

    localparam int unsigned BW = $clog2(BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TRANSMIT,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   ptr_nx;
    logic [CW-1:0]   ch_nx;
    logic [BW-1:0]   burst_cnt;
    logic [BW-1:0]   burst_cnt_nx;
    logic [N_CH-1:0] re_nx;
    logic            start_nx;
    logic            done_nx;
    logic            active_nx;
    logic [CW-1:0]   pick;
    logic            found;
    int unsigned     idx;

    // First non-empty channel starting at ptr, wrapping at N_CH-1.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!found && !empty_fifo[CW'(idx)]) begin
                pick  = CW'(idx);
                found = 1'b1;
            end
        end
    end

    // Next-state, grant bookkeeping and next-cycle output decode.
    always_comb begin
        state_nx     = state;
        ch_nx        = ch_sel;
        ptr_nx       = ptr;
        burst_cnt_nx = burst_cnt;
        re_nx        = '0;
        start_nx     = 1'b0;
        done_nx      = 1'b0;
        active_nx    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (en && !busy_tr && found) begin
                    state_nx = S_LOAD;
                    ch_nx    = pick;
                end
            end
            S_LOAD: begin
                state_nx = S_TRANSMIT;
            end
            S_TRANSMIT: begin
                state_nx     = S_HOLD;
                burst_cnt_nx = burst_cnt + BW'(1);
            end
            S_HOLD: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (!busy_tr) begin
                    if ((burst_cnt < BW'(BURST)) && en && !empty_fifo[ch_sel]) begin
                        state_nx = S_LOAD;
                    end else begin
                        state_nx     = S_IDLE;
                        done_nx      = 1'b1;
                        burst_cnt_nx = '0;
                        ptr_nx       = (32'(ch_sel) == N_CH - 1) ? '0 : ch_sel + CW'(1);
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Outputs are registered images of the next state, so they track state with no input path.
        for (int unsigned i = 0; i < N_CH; i++) begin
            re_nx[i] = (state_nx == S_LOAD) && (ch_nx == CW'(i));
        end
        start_nx  = (state_nx == S_TRANSMIT);
        active_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ch_sel    <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            re_fifo   <= '0;
            start_tr  <= 1'b0;
            done      <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nx;
            ch_sel    <= ch_nx;
            ptr       <= ptr_nx;
            burst_cnt <= burst_cnt_nx;
            re_fifo   <= re_nx;
            start_tr  <= start_nx;
            done      <= done_nx;
            active    <= active_nx;
        end
    end

endmodule

// File: tb/tb_tx_sched_fsm.sv
// Bench for tx_sched_fsm: FIFO-occupancy and transmitter models drive the DUT; a
// transaction-level round-robin model predicts the read order and grant ends.
module tb_tx_sched_fsm;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned BURST = 3;
    localparam int unsigned CW    = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N_CH-1:0] empty_fifo;
    logic            busy_tr;
    logic [N_CH-1:0] re_fifo;
    logic            start_tr;
    logic [CW-1:0]   ch_sel;
    logic            done;
    logic            active;

    logic busy_m;
    logic busy_f;
    int   cnt [N_CH];

    always #5 clk = ~clk;

    assign busy_tr = busy_m | busy_f;

    always_comb begin
        for (int i = 0; i < N_CH; i++) empty_fifo[i] = (cnt[i] == 0);
    end

    tx_sched_fsm #(.N_CH(N_CH), .BURST(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .empty_fifo(empty_fifo),
        .busy_tr   (busy_tr),
        .re_fifo   (re_fifo),
        .start_tr  (start_tr),
        .ch_sel    (ch_sel),
        .done      (done),
        .active    (active)
    );

    int n_chk = 0;
    int n_pass = 0;

    int              m_ptr;
    int              exp_rd[$];
    int              exp_dn[$];
    bit              use_model;
    int              k_busy;
    int              left;
    bit              pend;
    logic [N_CH-1:0] prev_re;
    int              cyc;
    int              last_rd_cyc;
    bit              in_grant;
    int              n_rd [N_CH];
    int              n_dn;
    int              done_ch;
    logic [N_CH-1:0] first_re;
    bit              first_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One cycle: transmitter model, FIFO pops and protocol/order checks at negedge.
    task automatic tick();
        int c;
        @(negedge clk);
        cyc++;
        if (left > 0) begin
            left--;
            busy_m = (left > 0);
        end
        if (pend) begin
            pend   = 1'b0;
            busy_m = 1'b1;
            left   = k_busy;
        end
        if (start_tr) begin
            pend = 1'b1;
            check("start_after_load", 32'(prev_re != 0), 32'd1);
        end
        if (re_fifo != 0) begin
            c = 0;
            for (int i = 0; i < N_CH; i++) if (re_fifo[i]) c = i;
            check("re_onehot", 32'($countones(re_fifo)), 32'd1);
            check("re_vs_chsel", 32'(re_fifo), 32'(1) << ch_sel);
            check("re_nonempty", 32'(cnt[c] > 0), 32'd1);
            if (cnt[c] > 0) cnt[c]--;
            n_rd[c]++;
            if (in_grant) check("word_spacing", 32'(cyc - last_rd_cyc), 32'(3 + k_busy));
            in_grant    = 1'b1;
            last_rd_cyc = cyc;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_re   = re_fifo;
            end
            if (use_model) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 32'(c), 32'hffff_ffff);
                else check("rd_order", 32'(c), 32'(exp_rd.pop_front()));
            end
        end
        if (done) begin
            in_grant = 1'b0;
            n_dn++;
            done_ch = 32'(ch_sel);
            if (use_model) begin
                if (exp_dn.size() == 0) check("done_unexpected", 32'(ch_sel), 32'hffff_ffff);
                else check("done_ch", 32'(ch_sel), 32'(exp_dn.pop_front()));
            end
        end
        prev_re = re_fifo;
    endtask

    // Load FIFO occupancies, predict the whole round-robin schedule, then drain.
    task automatic run_model(input int c0, input int c1, input int c2, input int c3);
        int  rem [N_CH];
        int  c;
        int  n;
        bit  any;
        int  budget;
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
        rem[0] = c0; rem[1] = c1; rem[2] = c2; rem[3] = c3;
        first_seen = 1'b0;
        forever begin
            any = 1'b0;
            c   = 0;
            for (int i = 0; i < N_CH; i++) begin
                if (!any && rem[(m_ptr + i) % N_CH] > 0) begin
                    any = 1'b1;
                    c   = (m_ptr + i) % N_CH;
                end
            end
            if (!any) break;
            n = (rem[c] < BURST) ? rem[c] : BURST;
            for (int j = 0; j < n; j++) exp_rd.push_back(c);
            exp_dn.push_back(c);
            rem[c] -= n;
            m_ptr = (c + 1) % N_CH;
        end
        use_model = 1'b1;
        budget    = 0;
        tick();
        while ((exp_rd.size() != 0 || exp_dn.size() != 0 || active) && budget < 3000) begin
            tick();
            budget++;
        end
        check("drain_timeout", 32'(budget < 3000), 32'd1);
        check("drain_left", 32'(cnt[0] + cnt[1] + cnt[2] + cnt[3]), 32'd0);
        use_model = 1'b0;
        exp_rd.delete();
        exp_dn.delete();
    endtask

    task automatic wait_start();
        int b;
        b = 0;
        do begin
            tick();
            b++;
        end while (!start_tr && b < 200);
        check("start_timeout", 32'(start_tr), 32'd1);
    endtask

    task automatic wait_done();
        int d0;
        int b;
        d0 = n_dn;
        b  = 0;
        while (n_dn == d0 && b < 500) begin
            tick();
            b++;
        end
        check("done_timeout", 32'(n_dn != d0), 32'd1);
    endtask

    initial begin
        int rd0;
        rst_n = 1'b0; en = 1'b1; busy_m = 1'b0; busy_f = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            cnt[i]  = 0;
            n_rd[i] = 0;
        end
        m_ptr = 0; use_model = 1'b0; k_busy = 1; left = 0; pend = 1'b0;
        prev_re = '0; cyc = 0; last_rd_cyc = 0; in_grant = 1'b0; n_dn = 0; done_ch = 0;
        first_re = '0; first_seen = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_outputs", {re_fifo, start_tr, done, active, ch_sel}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Wrap-around search: one word on ch2 leaves ptr at 3, then 3,0,1,2 -> ch2
        k_busy = 2;
        run_model(0, 0, 1, 0);
        run_model(0, 0, 2, 0);
        check("wrap_re", 32'(first_re), 32'h4);

        for (int s = 0; s < 20; s++) begin
            k_busy = $urandom_range(1, 4);
            run_model($urandom_range(0, 5), $urandom_range(0, 5),
                      $urandom_range(0, 5), $urandom_range(0, 5));
        end

        // busy_tr held in IDLE blocks the grant; LOAD follows one edge after release
        k_busy = 4;
        busy_f = 1'b1;
        cnt[1] = 2;
        repeat (6) tick();
        check("busy_blocks_grant", {31'd0, active}, 32'd0);
        busy_f = 1'b0;
        tick();
        check("grant_after_busy", 32'(re_fifo), 32'h2);
        wait_done();
        check("busy_grant_ch", 32'(done_ch), 32'd1);

        // en dropped during WAIT of the first word
        cnt[0] = 3;
        rd0    = n_rd[0];
        wait_start();
        tick();
        tick();
        en = 1'b0;
        wait_done();
        repeat (10) tick();
        check("en_drop_words", 32'(n_rd[0] - rd0), 32'd1);
        check("en_drop_idle", {31'd0, active}, 32'd0);
        cnt[0] = 0;
        en     = 1'b1;

        // Channel goes empty during HOLD
        cnt[2] = 3;
        rd0    = n_rd[2];
        wait_start();
        tick();
        cnt[2] = 0;
        wait_done();
        check("empty_hold_words", 32'(n_rd[2] - rd0), 32'd1);
        check("empty_hold_ch", 32'(done_ch), 32'd2);
        m_ptr = 3;

        // Reset during TRANSMIT of ch3; ptr restarts at 0 so ch0 beats ch3
        cnt[3] = 2;
        wait_start();
        check("rst_pre_ch", 32'(ch_sel), 32'd3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {re_fifo, start_tr, done, active, ch_sel}, 32'd0);
        pend = 1'b0; left = 0; busy_m = 1'b0; in_grant = 1'b0;
        rd0 = n_rd[0] + n_rd[1] + n_rd[2] + n_rd[3];
        repeat (3) tick();
        check("rst_no_reads", 32'(n_rd[0] + n_rd[1] + n_rd[2] + n_rd[3] - rd0), 32'd0);
        rst_n = 1'b1;
        m_ptr = 0;
        run_model(1, 0, 0, 2);
        check("post_rst_first", 32'(first_re), 32'h1);

        for (int s = 0; s < 5; s++) begin
            k_busy = $urandom_range(1, 4);
            run_model($urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
